// File: rtl/lsu_bus_master.sv
// ---------------------------------------------------------------------------
// lsu_bus_master
//
// Multi-cycle load/store unit between the MEM stage and a request/acknowledge
// data bus. Each request is decoded as one of three kinds:
//   - UART or timer access:        a one-cycle peripheral handshake (PERIPH)
//   - rejected misaligned access:  answered at once, with no side effects
//   - any other access:            one or two aligned bus beats (BEAT0/BEAT1)
// The unit then completes with a one-cycle response (RESP).
//
// Build option:
//   LSU_MISALIGN_SPLIT_EN  When defined, misaligned accesses are performed.
//                          An access that crosses a word boundary is split
//                          into two beats. When undefined, any access that is
//                          not naturally aligned is rejected through
//                          resp_misaligned.
//
// Ports:
//   clk, rst_n           clock; synchronous active-low reset
//   req_*                request from MEM stage (valid/ready handshake)
//   resp_*               one-cycle completion: load data, timeout error,
//                        misaligned rejection
//   bus_*                data bus master side. bus_req is held until bus_ack.
//   uart_write_enable    one-cycle pulse for a UART store
//   timer_write_enable   one-cycle pulse for a timer store
//   periph_addr/wdata    latched request address and data for peripherals
//   timer_read_data      timer read data, sampled in the PERIPH cycle
// ---------------------------------------------------------------------------
module lsu_bus_master #(
  parameter logic [31:0] UART_ADDR      = 32'h4000_0000,
  parameter logic [31:0] TIMER_BASE     = 32'h4000_4000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        resp_misaligned,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        uart_write_enable,
  output logic        timer_write_enable,
  output logic [31:0] periph_addr,
  output logic [31:0] periph_wdata,
  input  logic [31:0] timer_read_data
);

  typedef enum logic [2:0] {IDLE, PERIPH, BEAT0, BEAT1, RESP} state_t;

  // A beat times out on the cycle its wait count reaches TIMEOUT_CYCLES.
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);

  // Selects the low byte or halfword of an already-shifted word, then extends
  // it according to funct3. The signed right shift performs sign extension.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  f3);
    logic signed [31:0] s;
    logic        [31:0] r;
    s = '0;
    case (f3)
      3'b000: begin
        s = signed'({word[7:0], 24'h0}) >>> 24;
        r = s;
      end
      3'b001: begin
        s = signed'({word[15:0], 16'h0}) >>> 16;
        r = s;
      end
      3'b100:  r = {24'h0, word[7:0]};
      3'b101:  r = {16'h0, word[15:0]};
      default: r = word;
    endcase
    return r;
  endfunction

  state_t      state;

  // Attributes of the accepted request. These are data only and are not reset.
  logic        write_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic        timer_q;
  logic        split_q;
  logic [3:0]  be1_q;
  logic [31:0] wd1_q;
  logic [31:0] beat0_q;
  logic [31:0] tmo_cnt;

  // Request decode and lane alignment, evaluated on the incoming request
  logic [1:0]  req_off;
  logic [3:0]  size_mask;
  logic [7:0]  lane_mask;
  logic [63:0] wd_shift;
  logic        is_uart;
  logic        is_timer;
  logic        req_split;
  logic        req_misaligned;

  always_comb begin
    req_off  = req_addr[1:0];
    is_uart  = (req_addr == UART_ADDR);
    // Unsigned difference, so addresses below the base wrap and do not match.
    is_timer = ((req_addr - TIMER_BASE) <= 32'd12);
    case (req_funct3[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
    lane_mask = {4'b0000, size_mask} << req_off;
    wd_shift  = {32'h0, req_wdata} << {req_off, 3'b000};
`ifdef LSU_MISALIGN_SPLIT_EN
    req_split      = |lane_mask[7:4];
    req_misaligned = 1'b0;
`else
    req_split      = 1'b0;
    req_misaligned = (req_funct3[1:0] == 2'b01 && req_off[0]) ||
                     (req_funct3[1]            && req_off != 2'b00);
`endif
  end

  // Load alignment. On the final ack, the live bus word supplies the last
  // beat, so the response can be registered on the same edge.
  logic [31:0] beat0_sel;
  logic [31:0] load_word;

  always_comb begin
    beat0_sel = (state == BEAT0) ? bus_rdata : beat0_q;
    load_word = 32'({bus_rdata, beat0_sel} >> {off_q, 3'b000});
  end

  // Request attribute and beat-0 capture (data path, no reset)
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      write_q  <= req_write;
      funct3_q <= req_funct3;
      off_q    <= req_off;
      timer_q  <= is_timer;
      split_q  <= req_split;
      be1_q    <= lane_mask[7:4];
      wd1_q    <= wd_shift[63:32];
    end
    if (state == BEAT0 && bus_ack) begin
      beat0_q <= bus_rdata;
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state              <= IDLE;
      req_ready          <= 1'b1;
      resp_valid         <= 1'b0;
      resp_rdata         <= '0;
      resp_error         <= 1'b0;
      resp_misaligned    <= 1'b0;
      bus_req            <= 1'b0;
      bus_we             <= 1'b0;
      bus_addr           <= '0;
      bus_be             <= '0;
      bus_wdata          <= '0;
      uart_write_enable  <= 1'b0;
      timer_write_enable <= 1'b0;
      periph_addr        <= '0;
      periph_wdata       <= '0;
      tmo_cnt            <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready    <= 1'b0;
            periph_addr  <= req_addr;
            periph_wdata <= req_wdata;
            if (is_uart || is_timer) begin
              state              <= PERIPH;
              uart_write_enable  <= req_write && is_uart;
              timer_write_enable <= req_write && is_timer;
            end else if (req_misaligned) begin
              state           <= RESP;
              resp_valid      <= 1'b1;
              resp_misaligned <= 1'b1;
              resp_error      <= 1'b0;
              resp_rdata      <= '0;
            end else begin
              state     <= BEAT0;
              bus_req   <= 1'b1;
              bus_we    <= req_write;
              bus_addr  <= {req_addr[31:2], 2'b00};
              bus_be    <= lane_mask[3:0];
              bus_wdata <= wd_shift[31:0];
              tmo_cnt   <= '0;
            end
          end
        end

        PERIPH: begin
          uart_write_enable  <= 1'b0;
          timer_write_enable <= 1'b0;
          state              <= RESP;
          resp_valid         <= 1'b1;
          // UART reads return 0. Timer reads pass through without extension.
          resp_rdata         <= (!write_q && timer_q) ? timer_read_data : 32'h0;
        end

        BEAT0, BEAT1: begin
          if (bus_ack) begin
            if (state == BEAT0 && split_q) begin
              // bus_req stays high. The second beat starts on the next cycle.
              state     <= BEAT1;
              bus_addr  <= bus_addr + 32'd4;
              bus_be    <= be1_q;
              bus_wdata <= wd1_q;
              tmo_cnt   <= '0;
            end else begin
              state      <= RESP;
              bus_req    <= 1'b0;
              bus_we     <= 1'b0;
              bus_be     <= '0;
              resp_valid <= 1'b1;
              resp_rdata <= write_q ? 32'h0 : load_extend(load_word, funct3_q);
            end
          end else if (TMO_EN && tmo_cnt == TMO_LAST) begin
            // A beat-0 store that was already acked is not rolled back.
            state      <= RESP;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_be     <= '0;
            resp_valid <= 1'b1;
            resp_error <= 1'b1;
            resp_rdata <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end

        RESP: begin
          state           <= IDLE;
          req_ready       <= 1'b1;
          resp_valid      <= 1'b0;
          resp_error      <= 1'b0;
          resp_misaligned <= 1'b0;
          resp_rdata      <= '0;
        end

        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_bus_master.sv
module tb_lsu_bus_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        resp_misaligned;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        uart_write_enable;
  logic        timer_write_enable;
  logic [31:0] periph_addr;
  logic [31:0] periph_wdata;
  logic [31:0] timer_read_data;

  lsu_bus_master #(
    .UART_ADDR     (32'h4000_0000),
    .TIMER_BASE    (32'h4000_4000),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_write         (req_write),
    .req_funct3        (req_funct3),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .resp_valid        (resp_valid),
    .resp_rdata        (resp_rdata),
    .resp_error        (resp_error),
    .resp_misaligned   (resp_misaligned),
    .bus_req           (bus_req),
    .bus_we            (bus_we),
    .bus_addr          (bus_addr),
    .bus_be            (bus_be),
    .bus_wdata         (bus_wdata),
    .bus_ack           (bus_ack),
    .bus_rdata         (bus_rdata),
    .uart_write_enable (uart_write_enable),
    .timer_write_enable(timer_write_enable),
    .periph_addr       (periph_addr),
    .periph_wdata      (periph_wdata),
    .timer_read_data   (timer_read_data)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        mis;
  } exp_t;

  exp_t sb[$];

  int n_cmp   = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Drives one request. The accept cycle is the one in which valid && ready
  // is seen. When push is set, the expected response goes to the scoreboard.
  task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] erd,
                       input logic eerr, input logic emis, input logic push);
    exp_t e;
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    if (push) begin
      e.rdata = erd;
      e.err   = eerr;
      e.mis   = emis;
      sb.push_back(e);
    end
    @(negedge clk);
    chk1("req_ready_at_accept", req_ready, 1'b1);
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Serves one bus beat: checks the request fields, inserts wait cycles,
  // then acks with rd.
  task automatic beat(input string tag, input logic [31:0] ea, input logic [3:0] ebe,
                      input logic ewe, input logic [31:0] ewd, input int waits,
                      input logic [31:0] rd);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk1({tag, ".bus_req"}, bus_req, 1'b1);
    chk({tag, ".bus_addr"}, bus_addr, ea);
    chk({tag, ".bus_be"}, {28'h0, bus_be}, {28'h0, ebe});
    chk1({tag, ".bus_we"}, bus_we, ewe);
    if (ewe) chk({tag, ".bus_wdata"}, bus_wdata, ewd);
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      chk({tag, ".bus_addr_hold"}, bus_addr, ea);
    end
    bus_ack   = 1'b1;
    bus_rdata = rd;
    @(posedge clk);
    #1;
    bus_ack = 1'b0;
  endtask

  // Waits for resp_valid, pops the scoreboard and compares. It returns the
  // latency from the accept cycle and the number of cycles with bus_req high.
  task automatic wait_resp(input string tag, output int lat, output int n_bus);
    int   n;
    exp_t e;
    n     = 0;
    n_bus = 0;
    @(negedge clk);
    while (!resp_valid && n < 20) begin
      if (bus_req) n_bus++;
      @(negedge clk);
      n++;
    end
    lat = cyc - acc_cyc;
    chk1({tag, ".resp_valid"}, resp_valid, 1'b1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (resp_valid) begin
        chk({tag, ".resp_rdata"}, resp_rdata, e.rdata);
        chk1({tag, ".resp_error"}, resp_error, e.err);
        chk1({tag, ".resp_misaligned"}, resp_misaligned, e.mis);
      end
    end
  endtask

  task automatic settle(input string tag);
    @(negedge clk);
    chk1({tag, ".resp_pulse"}, resp_valid, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic bus_op(input string tag, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] ea, input logic [3:0] ebe,
                        input logic [31:0] ewd, input int waits,
                        input logic [31:0] rd, input logic [31:0] erd,
                        output int lat);
    int nb;
    issue(wr, f3, a, wd, erd, 1'b0, 1'b0, 1'b1);
    beat(tag, ea, ebe, wr, ewd, waits, rd);
    wait_resp(tag, lat, nb);
    settle(tag);
  endtask

  initial begin
    int lat;
    int nb;
    int n_resp;
    int n_busq;

    rst_n           = 1'b0;
    req_valid       = 1'b0;
    req_write       = 1'b0;
    req_funct3      = 3'b000;
    req_addr        = 32'h0;
    req_wdata       = 32'h0;
    bus_ack         = 1'b0;
    bus_rdata       = 32'h0;
    timer_read_data = 32'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst.req_ready", req_ready, 1'b1);
    chk1("rst.bus_req", bus_req, 1'b0);
    chk1("rst.resp_valid", resp_valid, 1'b0);
    chk1("rst.uart_we", uart_write_enable, 1'b0);
    chk1("rst.timer_we", timer_write_enable, 1'b0);
    chk("rst.bus_addr", bus_addr, 32'h0);
    chk("rst.resp_rdata", resp_rdata, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Aligned word store with two wait cycles
    bus_op("sw", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h100, 4'b1111,
           32'hDEADBEEF, 2, 32'h0, 32'h0, lat);
    chk("sw.latency", lat, 4);

    // Loads with extension
    bus_op("lb", 1'b0, 3'b000, 32'h103, 32'h0, 32'h100, 4'b1000, 32'h0, 1,
           32'h80112233, 32'hFFFFFF80, lat);
    bus_op("lbu", 1'b0, 3'b100, 32'h103, 32'h0, 32'h100, 4'b1000, 32'h0, 0,
           32'h80112233, 32'h00000080, lat);
    bus_op("lhu", 1'b0, 3'b101, 32'h102, 32'h0, 32'h100, 4'b1100, 32'h0, 0,
           32'h80112233, 32'h00008011, lat);
    bus_op("lh_neg", 1'b0, 3'b001, 32'h102, 32'h0, 32'h100, 4'b1100, 32'h0, 0,
           32'h80112233, 32'hFFFF8011, lat);
    bus_op("lh_pos", 1'b0, 3'b001, 32'h100, 32'h0, 32'h100, 4'b0011, 32'h0, 0,
           32'h80112233, 32'h00002233, lat);
    bus_op("lw", 1'b0, 3'b010, 32'h104, 32'h0, 32'h104, 4'b1111, 32'h0, 0,
           32'h80112233, 32'h80112233, lat);
    chk("lw.latency_zero_wait", lat, 2);

    // Sub-word stores with lane placement
    bus_op("sb", 1'b1, 3'b000, 32'h101, 32'h000000AB, 32'h100, 4'b0010,
           32'h0000AB00, 0, 32'h0, 32'h0, lat);
    bus_op("sh", 1'b1, 3'b001, 32'h102, 32'h00001234, 32'h100, 4'b1100,
           32'h12340000, 1, 32'h0, 32'h0, lat);

`ifdef LSU_MISALIGN_SPLIT_EN
    // Word-crossing load in two beats
    issue(1'b0, 3'b010, 32'h0FE, 32'h0, 32'hCCDDAABB, 1'b0, 1'b0, 1'b1);
    beat("lw_split.b0", 32'h0FC, 4'b1100, 1'b0, 32'h0, 0, 32'hAABB0000);
    beat("lw_split.b1", 32'h100, 4'b0011, 1'b0, 32'h0, 1, 32'h0000CCDD);
    wait_resp("lw_split", lat, nb);
    settle("lw_split");
    // Word-crossing store in two beats
    issue(1'b1, 3'b010, 32'h0FF, 32'h11223344, 32'h0, 1'b0, 1'b0, 1'b1);
    beat("sw_split.b0", 32'h0FC, 4'b1000, 1'b1, 32'h44000000, 0, 32'h0);
    beat("sw_split.b1", 32'h100, 4'b0111, 1'b1, 32'h00112233, 0, 32'h0);
    wait_resp("sw_split", lat, nb);
    settle("sw_split");
    // Misaligned access inside one word takes a single beat
    bus_op("lh_inword", 1'b0, 3'b001, 32'h101, 32'h0, 32'h100, 4'b0110, 32'h0, 0,
           32'h00F00D00, 32'hFFFFF00D, lat);
`else
    // Misaligned accesses are rejected with no bus activity
    issue(1'b0, 3'b010, 32'h0FE, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    wait_resp("lw_mis", lat, nb);
    chk("lw_mis.bus_cycles", nb, 0);
    chk1("lw_mis.bus_req", bus_req, 1'b0);
    settle("lw_mis");
    issue(1'b1, 3'b001, 32'h101, 32'h5555, 32'h0, 1'b0, 1'b1, 1'b1);
    wait_resp("sh_mis", lat, nb);
    chk("sh_mis.bus_cycles", nb, 0);
    chk1("sh_mis.bus_req", bus_req, 1'b0);
    settle("sh_mis");
`endif

    // UART store
    issue(1'b1, 3'b000, 32'h4000_0000, 32'h00000041, 32'h0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk1("uart.we", uart_write_enable, 1'b1);
    chk1("uart.timer_we", timer_write_enable, 1'b0);
    chk1("uart.bus_req", bus_req, 1'b0);
    chk("uart.wdata", {24'h0, periph_wdata[7:0]}, 32'h41);
    chk("uart.addr", periph_addr, 32'h4000_0000);
    wait_resp("uart", lat, nb);
    chk1("uart.we_pulse", uart_write_enable, 1'b0);
    chk("uart.bus_cycles", nb, 0);
    settle("uart");

    // Timer load passes data through raw
    timer_read_data = 32'h12345678;
    issue(1'b0, 3'b010, 32'h4000_4008, 32'h0, 32'h12345678, 1'b0, 1'b0, 1'b1);
    wait_resp("timer_lw", lat, nb);
    chk("timer_lw.bus_cycles", nb, 0);
    settle("timer_lw");

    // Timer store at the top of the window
    issue(1'b1, 3'b010, 32'h4000_400C, 32'h00000099, 32'h0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk1("timer_sw.we", timer_write_enable, 1'b1);
    chk1("timer_sw.uart_we", uart_write_enable, 1'b0);
    wait_resp("timer_sw", lat, nb);
    settle("timer_sw");

    // UART load returns 0
    issue(1'b0, 3'b010, 32'h4000_0000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    wait_resp("uart_lw", lat, nb);
    settle("uart_lw");

    // Just past the timer window goes to the bus
    bus_op("past_timer", 1'b0, 3'b010, 32'h4000_4010, 32'h0, 32'h4000_4010, 4'b1111,
           32'h0, 0, 32'hCAFEF00D, 32'hCAFEF00D, lat);

    // Timeout with no ack
    issue(1'b0, 3'b010, 32'h200, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    wait_resp("tmo", lat, nb);
    chk("tmo.bus_cycles", nb, 4);
    chk1("tmo.bus_req_dropped", bus_req, 1'b0);
    settle("tmo");

    // Reset during BEAT0, then a late ack that must be ignored
    issue(1'b0, 3'b010, 32'h300, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk1("rst_mid.bus_req_before", bus_req, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk1("rst_mid.bus_req", bus_req, 1'b0);
    chk1("rst_mid.req_ready", req_ready, 1'b1);
    bus_ack   = 1'b1;
    bus_rdata = 32'h5A5A5A5A;
    @(posedge clk);
    #1;
    bus_ack = 1'b0;
    n_resp  = 0;
    n_busq  = 0;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid) n_resp++;
      if (bus_req) n_busq++;
    end
    chk("rst_mid.no_resp", n_resp, 0);
    chk("rst_mid.no_bus", n_busq, 0);
    @(posedge clk);
    #1;

    // Recovery after reset
    bus_op("recover", 1'b0, 3'b010, 32'h104, 32'h0, 32'h104, 4'b1111, 32'h0, 0,
           32'h0BADF00D, 32'h0BADF00D, lat);
    chk("recover.latency", lat, 2);

    chk("sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_bus_master.md
Name: lsu_bus_master

Overview:
Multi-cycle load/store unit sitting between the MEM stage and a request/acknowledge data bus, replacing purely combinational DMEM access. It decodes UART/timer space by parameter, aligns and extends data, applies a bus timeout, and either splits misaligned word-crossing accesses into two aligned beats or flags them (see Optional Feature).

Parameters:
UART_ADDR, 32'h40000000, exact UART TX address (write-only; reads return 0)
TIMER_BASE, 32'h40004000, timer window base; window is TIMER_BASE..TIMER_BASE+12 inclusive
TIMEOUT_CYCLES, 16, max cycles a beat waits for bus_ack; 0 disables timeout

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  1  access request from MEM stage
req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready
req_write  in  1  1 = store, 0 = load
req_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (stores use 000/001/010)
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  aligned, extended load data; 0 for stores and errors
resp_error  out  1  bus timeout, qualified by resp_valid
resp_misaligned  out  1  misaligned access rejected, qualified by resp_valid
bus_req  out  1  bus request, held until bus_ack
bus_we  out  1  bus write
bus_addr  out  32  word-aligned address (bits [1:0] = 0)
bus_be  out  4  byte enables
bus_wdata  out  32  lane-aligned write data
bus_ack  in  1  beat complete; ignored while bus_req = 0
bus_rdata  in  32  read word, valid with bus_ack
uart_write_enable  out  1  one-cycle pulse, UART store
timer_write_enable  out  1  one-cycle pulse, timer store
periph_addr  out  32  latched request address for peripherals
periph_wdata  out  32  latched req_wdata (UART uses [7:0])
timer_read_data  in  32  timer read data, sampled in PERIPH

Behaviour:
- States: IDLE, PERIPH, BEAT0, BEAT1, RESP. Reset (rst_n = 0 at a clk edge) forces IDLE. All outputs reset to 0 except req_ready = 1. Reset mid-transaction abandons the beat and drops bus_req on the next edge. A late bus_ack is ignored.
- Accept: address, funct3, data and write flag are latched. Next state is PERIPH for UART/timer addresses, RESP with resp_misaligned = 1 for rejected misaligned accesses (no bus or peripheral activity), otherwise BEAT0.
- PERIPH, 1 cycle: drives uart/timer_write_enable for stores. A timer load captures timer_read_data raw, with no extension. Then RESP.
- BEATn: bus_req = 1, and bus_addr/be/wdata/we are stable until ack. bus_ack in the same cycle bus_req first rises is legal (zero-wait). On ack, rdata is captured into beat register n. The next state is BEAT1 if the access is split and n = 0, else RESP.
- Timeout: a per-beat counter clears on beat entry. When the count reaches TIMEOUT_CYCLES with no ack, the unit goes to RESP with resp_error = 1 and resp_rdata = 0. A beat-0 timeout skips BEAT1. A beat-1 timeout after a beat-0 write leaves beat 0 written; there is no rollback.
- RESP, 1 cycle: resp_valid = 1, then IDLE. Back-to-back throughput is therefore one access per 3 cycles minimum.
- Lane rules: offset o = addr[1:0]; size s = 1/2/4. Beat-0 address = addr & ~3, beat-1 address = beat-0 + 4 (32-bit wrap from 0xFFFFFFFC to 0).
- Store: 64-bit shifted = {32'b0, wdata} << 8*o. Beat-0 wdata = shifted[31:0], be0 = mask[3:0]; beat-1 wdata = shifted[63:32], be1 = mask[7:4], where mask = ((1<<s)-1) << o. Split iff mask[7:4] != 0.
- Load: combined = {beat1, beat0} >> 8*o, then sign- or zero-extend the low s bytes per funct3.

Optional Feature:
LSU_MISALIGN_SPLIT_EN defined: misaligned accesses within a word complete in one beat (e.g. LH at o = 1, be = 0110). Word-crossing accesses use two beats. resp_misaligned is never set.
Undefined: any access not naturally aligned (H with o[0] = 1, W with o != 0) is rejected via resp_misaligned = 1 with no side effects. BEAT1 is unreachable.

Test Plan:
- SW 0xDEADBEEF to 0x100, ack after 2 cycles -> one beat: bus_addr 0x100, be 1111, wdata 0xDEADBEEF; resp_valid 4 cycles after accept; resp_error 0.
- LB at 0x103, bus_rdata 0x80112233 -> resp_rdata 0xFFFFFF80. LBU at 0x103 -> 0x00000080. LHU at 0x102 -> 0x00008011.
- Split macro on: LW at 0x0FE, beat rdata 0xAABB0000 then 0x0000CCDD -> beats at 0x0FC/0x100, resp_rdata 0xCCDDAABB. SW 0x11223344 at 0x0FF -> be 1000 wdata[31:24] = 0x44, then be 0111 wdata[23:0] = 0x112233. Macro off: same LW -> resp_misaligned = 1, bus_req never asserted.
- SB 0x41 to 0x40000000 -> uart_write_enable 1 cycle, periph_wdata[7:0] = 0x41, no bus_req. LW at 0x40004008 with timer_read_data 0x12345678 -> resp_rdata 0x12345678.
- TIMEOUT_CYCLES = 4, no ack -> resp_error = 1, resp_rdata 0, bus_req drops. Reset asserted during BEAT0 -> IDLE, req_ready = 1, bus_req = 0 next cycle, no resp_valid.
